// File: rtl/jzjpcc_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states and
// the bit layout of the command and status words seen by the core.
package jzjpcc_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // txCommand layout (word written by the core)
  localparam int unsigned CMD_DATA_LSB    = 0;
  localparam int unsigned CMD_DATA_MSB    = 7;
  localparam int unsigned CMD_TOGGLE_BIT  = 8;
  localparam int unsigned CMD_CLR_OVF_BIT = 9;

  // txStatus layout (word read by the core)
  localparam int unsigned STAT_FULL_BIT   = 0;
  localparam int unsigned STAT_EMPTY_BIT  = 1;
  localparam int unsigned STAT_BUSY_BIT   = 2;
  localparam int unsigned STAT_ACK_BIT    = 3;
  localparam int unsigned STAT_COUNT_LSB  = 4;
  localparam int unsigned STAT_COUNT_MSB  = 7;
  localparam int unsigned STAT_OVF_BIT    = 8;

endpackage

// File: rtl/jzjpcc_sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter so that "full" is
// distinguishable from "empty" when the wrapping pointers coincide.
// The head entry is presented combinationally on pop_data.
module jzjpcc_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == {CW{1'b0}});
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Next pointer and occupancy values; a push and a pop on one edge cancel in the count.
  always_comb begin
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy guards every read.
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/jzjpcc_mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter. The core writes a byte by flipping the
// toggle bit of txCommand; bytes are queued in a FIFO and shifted out LSB
// first. txStatus reports FIFO state, busy, a write acknowledge and overflow.
module jzjpcc_mmio_uart_tx
  import jzjpcc_uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] txCommand,
  output logic [31:0] txStatus,
  output logic        txd
);

  localparam int unsigned BW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLOCKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          armed_q, armed_d;
  logic          last_toggle_q, last_toggle_d;
  logic          ack_q, ack_d;
  logic          overflow_q, overflow_d;

  logic          write_req_s;
  logic          push_s;
  logic          pop_s;
  logic [7:0]    fifo_data_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic          cmd_unused_s;

  // Upper command bits carry nothing for this peripheral.
  assign cmd_unused_s = ^txCommand[31:10];

  jzjpcc_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_s),
    .push_data (txCommand[CMD_DATA_MSB:CMD_DATA_LSB]),
    .pop       (pop_s),
    .pop_data  (fifo_data_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Write-request detection, acknowledge echo and sticky overflow flag.
  always_comb begin
    armed_d       = 1'b1;
    last_toggle_d = last_toggle_q;
    ack_d         = ack_q;
    overflow_d    = overflow_q;
    write_req_s   = armed_q && (txCommand[CMD_TOGGLE_BIT] != last_toggle_q);
    push_s        = write_req_s && !fifo_full_s;
    if (!armed_q) begin
      // First edge after reset only samples the toggle; nothing is queued.
      last_toggle_d = txCommand[CMD_TOGGLE_BIT];
    end else if (write_req_s) begin
      last_toggle_d = txCommand[CMD_TOGGLE_BIT];
      ack_d         = txCommand[CMD_TOGGLE_BIT];
    end else begin
      last_toggle_d = last_toggle_q;
    end
    // A byte dropped on this edge wins over a simultaneous clear.
    if (write_req_s && fifo_full_s) begin
      overflow_d = 1'b1;
    end else if (txCommand[CMD_CLR_OVF_BIT]) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Frame sequencer: baud counting, bit indexing and FIFO pops.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_d = fifo_data_s;
          baud_d  = {BW{1'b0}};
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = {BW{1'b0}};
          idx_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d  = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = {BW{1'b0}};
          if (idx_q == 3'd7) begin
            idx_d   = 3'd0;
            state_d = STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = {BW{1'b0}};
          if (!fifo_empty_s) begin
            // Chain straight into the next frame without an idle bit.
            pop_s   = 1'b1;
            shift_d = fifo_data_s;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = {BW{1'b0}};
        idx_d   = 3'd0;
      end
    endcase
  end

  // Line level for the upcoming cycle, registered so txd never glitches.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      IDLE:    txd_d = 1'b1;
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[idx_d];
      STOP:    txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase
  end

  // Status word assembled from registered state only.
  always_comb begin
    txStatus = 32'd0;
    txStatus[STAT_FULL_BIT]                  = fifo_full_s;
    txStatus[STAT_EMPTY_BIT]                 = fifo_empty_s;
    txStatus[STAT_BUSY_BIT]                  = (state_q != IDLE);
    txStatus[STAT_ACK_BIT]                   = ack_q;
    txStatus[STAT_COUNT_MSB:STAT_COUNT_LSB]  = 4'(fifo_count_s);
    txStatus[STAT_OVF_BIT]                   = overflow_q;
  end

  assign txd = txd_q;

  // Transmitter state registers; reset abandons any frame in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      baud_q        <= {BW{1'b0}};
      idx_q         <= 3'd0;
      shift_q       <= 8'd0;
      txd_q         <= 1'b1;
      armed_q       <= 1'b0;
      last_toggle_q <= 1'b0;
      ack_q         <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      baud_q        <= baud_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      txd_q         <= txd_d;
      armed_q       <= armed_d;
      last_toggle_q <= last_toggle_d;
      ack_q         <= ack_d;
      overflow_q    <= overflow_d;
    end
  end

endmodule

// File: tb/tb_jzjpcc_mmio_uart_tx.sv
// Directed bench for the MMIO UART transmitter. Bytes are pushed onto an
// expected queue when written; a line monitor decodes every frame on txd
// cycle by cycle and pops the queue to compare.
module tb_jzjpcc_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] txCommand;
  logic [31:0] txStatus;
  logic        txd;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          frames_started = 0;
  int          frames_done = 0;
  logic [7:0]  exp_q[$];
  int          start_q[$];
  int          end_q[$];
  logic        tog;

  jzjpcc_mmio_uart_tx #(
    .CLOCKS_PER_BIT (CPB),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .txCommand (txCommand),
    .txStatus  (txStatus),
    .txd       (txd)
  );

  initial forever #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] st(input logic full, input logic empty, input logic busy,
                                     input logic ack, input int cnt, input logic ovf);
    st = {23'd0, ovf, 4'(cnt), ack, busy, empty, full};
  endfunction

  // Flip the toggle with a new byte; returns at the negedge after the write edge.
  task automatic do_write(input logic [7:0] b, input logic expect_queued);
    tog = ~tog;
    txCommand = {22'd0, 1'b0, tog, b};
    if (expect_queued) exp_q.push_back(b);
    @(negedge clock);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (frames_done < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk("frames_done", 32'(frames_done), 32'(n));
  endtask

  // Line monitor: decodes every frame, one comparison per sampled cycle.
  initial begin
    logic [7:0] exp_b;
    logic       exp_bit;
    logic       aborted;
    int         pos;
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && txd === 1'b0) begin
        frames_started++;
        start_q.push_back(cyc);
        chk("frame_expected", 32'(exp_q.size() > 0), 32'd1);
        exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'd0;
        aborted = 1'b0;
        for (int k = 0; k < 10 * CPB; k++) begin
          if (k > 0) @(negedge clock);
          if (reset !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          pos = k / CPB;
          if (pos == 0) exp_bit = 1'b0;
          else if (pos == 9) exp_bit = 1'b1;
          else exp_bit = exp_b[pos-1];
          chk($sformatf("txd_byte%02h_pos%0d", exp_b, pos), {31'd0, txd}, {31'd0, exp_bit});
        end
        if (!aborted) begin
          frames_done++;
          end_q.push_back(cyc);
        end
      end
    end
  end

  initial begin
    logic [7:0] burst [5];
    int         span;
    int         k;
    burst[0] = 8'h3C; burst[1] = 8'hC3; burst[2] = 8'h0F; burst[3] = 8'hF0; burst[4] = 8'h81;

    // Reset, then release with toggle already high: nothing must be queued.
    txCommand = 32'h00000155;
    tog = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_status", txStatus, 32'h00000002);
    chk("reset_txd", {31'd0, txd}, 32'd1);
    reset = 1'b1;
    repeat (6) begin
      @(negedge clock);
      chk("release_status", txStatus, 32'h00000002);
      chk("release_txd", {31'd0, txd}, 32'd1);
    end
    chk("release_no_frame", 32'(frames_started), 32'd0);

    // Single byte: count visible next cycle, then a full frame.
    do_write(8'hA5, 1'b1);
    chk("single_count", txStatus, st(1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0));
    wait_frames(1, 100);
    @(negedge clock);
    chk("single_idle", txStatus, st(1'b0, 1'b1, 1'b0, tog, 0, 1'b0));

    // Five writes in consecutive cycles: first pops, four fill the FIFO.
    for (int i = 0; i < 5; i++) do_write(burst[i], 1'b1);
    chk("burst_full", txStatus, st(1'b1, 1'b0, 1'b1, tog, DEPTH, 1'b0));

    // Write into a full FIFO is dropped and flags overflow.
    do_write(8'hEE, 1'b0);
    chk("overflow_set", txStatus, st(1'b1, 1'b0, 1'b1, tog, DEPTH, 1'b1));
    txCommand[9] = 1'b1;
    @(negedge clock);
    txCommand[9] = 1'b0;
    chk("overflow_clear", txStatus, st(1'b1, 1'b0, 1'b1, tog, DEPTH, 1'b0));

    // All five burst bytes go out back to back.
    wait_frames(6, 400);
    span = (end_q.size() >= 6 && start_q.size() >= 2) ? (end_q[5] - start_q[1] + 1) : -1;
    chk("burst_span", 32'(span), 32'(5 * 10 * CPB));
    @(negedge clock);
    chk("burst_idle", txStatus, st(1'b0, 1'b1, 1'b0, tog, 0, 1'b0));

    // Reset in data bit 3 with two bytes still queued.
    do_write(8'h12, 1'b1);
    do_write(8'h34, 1'b1);
    do_write(8'h56, 1'b1);
    k = 0;
    while (frames_started < 7 && k < 50) begin
      @(negedge clock);
      k++;
    end
    chk("abort_frame_started", 32'(frames_started), 32'd7);
    repeat (15) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("abort_txd", {31'd0, txd}, 32'd1);
    chk("abort_status", txStatus, 32'h00000002);
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (60) begin
      @(negedge clock);
      chk("after_abort_txd", {31'd0, txd}, 32'd1);
    end
    chk("after_abort_frames", 32'(frames_started), 32'd7);
    chk("after_abort_status", txStatus, 32'h00000002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
